// File: rtl/spi_byte_master_if.sv
// Byte-level SPI master bus: sequencer-side handshake plus the serial pins.
// The master modport is the shift engine's view; slave is the sequencer/bench view.
interface spi_byte_master_if;
    logic       start;
    logic [7:0] tx_data;
    logic       miso;
    logic       sclk;
    logic       mosi;
    logic [7:0] rx_data;
    logic       spi_active;
    logic       done;

    modport master (
        input  start, tx_data, miso,
        output sclk, mosi, rx_data, spi_active, done
    );

    modport slave (
        output start, tx_data, miso,
        input  sclk, mosi, rx_data, spi_active, done
    );
endinterface

// File: rtl/spi_byte_master.sv
// SPI mode-0 byte shift engine: MSB-first TX on mosi, simultaneous RX, CPOL=0 sclk.
// Optional macro SPI_BYTE_MASTER_LOOPBACK_EN: receive path samples internal mosi instead of miso.
module spi_byte_master #(
    parameter int unsigned CLK_DIV = 50
) (
    input  logic              clk,
    input  logic              rst,
    spi_byte_master_if.master bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [15:0] div_cnt_q, div_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        sclk_q, sclk_d;
    logic        active_q, active_d;
    logic        done_q, done_d;
    logic        rx_bit;
    logic        half_end;

`ifdef SPI_BYTE_MASTER_LOOPBACK_EN
    logic unused_miso;
    assign unused_miso = bus.miso;
    assign rx_bit      = tx_sh_q[7];
`else
    assign rx_bit      = bus.miso;
`endif

    assign half_end = (div_cnt_q == DIV_LAST);

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        sclk_d    = sclk_q;
        active_d  = active_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    tx_sh_d   = bus.tx_data;
                    bit_cnt_d = 3'd7;
                    div_cnt_d = 16'd0;
                    active_d  = 1'b1;
                    state_d   = LOW;
                end
            end
            LOW: begin
                if (half_end) begin
                    // Sample on the same edge that raises sclk (mode 0).
                    sclk_d    = 1'b1;
                    rx_sh_d   = {rx_sh_q[6:0], rx_bit};
                    div_cnt_d = 16'd0;
                    state_d   = HIGH;
                end else begin
                    div_cnt_d = div_cnt_q + 16'd1;
                end
            end
            HIGH: begin
                if (half_end) begin
                    sclk_d    = 1'b0;
                    div_cnt_d = 16'd0;
                    if (bit_cnt_q == 3'd0) begin
                        rx_data_d = rx_sh_q;
                        done_d    = 1'b1;
                        active_d  = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        // mosi advances only on falling sclk edges.
                        tx_sh_d   = {tx_sh_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q - 3'd1;
                        state_d   = LOW;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d  = IDLE;
                sclk_d   = 1'b0;
                active_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            div_cnt_q <= 16'd0;
            bit_cnt_q <= 3'd0;
            tx_sh_q   <= 8'h00;
            rx_sh_q   <= 8'h00;
            rx_data_q <= 8'h00;
            sclk_q    <= 1'b0;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            sclk_q    <= sclk_d;
            active_q  <= active_d;
            done_q    <= done_d;
        end
    end

    // tx_sh[7] is untouched in IDLE, so mosi holds the last driven bit.
    assign bus.mosi       = tx_sh_q[7];
    assign bus.sclk       = sclk_q;
    assign bus.rx_data    = rx_data_q;
    assign bus.spi_active = active_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_spi_byte_master.sv
// Self-checking bench for spi_byte_master: a CLK_DIV=4 and a CLK_DIV=1 instance,
// a mode-0 slave model, and a byte-level reference model of each transfer.
module tb_spi_byte_master;
    logic clk = 1'b0;
    logic clk_en = 1'b0;
    logic rst = 1'b1;

    logic       start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       sel = 1'b0;       // 0: CLK_DIV=4 instance, 1: CLK_DIV=1 instance

    logic [7:0] slave_sh = 8'h00;
    logic [7:0] slave_next = 8'h00;
    int         slave_cnt = 0;

    int n_assert = 0;
    int n_fail = 0;

    spi_byte_master_if if4 ();
    spi_byte_master_if if1 ();

    spi_byte_master #(.CLK_DIV(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.master));
    spi_byte_master #(.CLK_DIV(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.master));

    assign if4.start   = start & ~sel;
    assign if1.start   = start & sel;
    assign if4.tx_data = tx_data;
    assign if1.tx_data = tx_data;
    assign if4.miso    = slave_sh[7];
    assign if1.miso    = slave_sh[7];

    logic       m_sclk, m_mosi, m_active, m_done;
    logic [7:0] m_rx;
    assign m_sclk   = sel ? if1.sclk       : if4.sclk;
    assign m_mosi   = sel ? if1.mosi       : if4.mosi;
    assign m_active = sel ? if1.spi_active : if4.spi_active;
    assign m_done   = sel ? if1.done       : if4.done;
    assign m_rx     = sel ? if1.rx_data    : if4.rx_data;

    always #5 if (clk_en) clk = ~clk;

    // Mode-0 slave: bit 7 presented up front, next bit after each falling sclk.
    always @(negedge m_sclk) begin
        if (slave_cnt == 7) begin
            slave_cnt = 0;
            slave_sh  = slave_next;
        end else begin
            slave_cnt = slave_cnt + 1;
            slave_sh  = {slave_sh[6:0], 1'b0};
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] expected_rx(input logic [7:0] tx, input logic [7:0] slv);
`ifdef SPI_BYTE_MASTER_LOOPBACK_EN
        return tx;
`else
        return slv;
`endif
    endfunction

    // One full transfer on the selected instance. issue=0 means the transfer was
    // already accepted back-to-back; keep=1 holds start high into the done cycle
    // with nxt/nxt_slv as the follow-on byte; ign_cyc>0 pulses a stray start.
    task automatic xfer(input string tag, input logic [7:0] tx, input logic [7:0] slv,
                        input bit issue, input bit keep, input logic [7:0] nxt,
                        input logic [7:0] nxt_slv, input int ign_cyc);
        int         div;
        int         n;
        int         rises;
        int         extra_done;
        logic [7:0] bits;
        logic       prev;
        div = sel ? 1 : 4;
        if (issue) begin
            start      = 1'b1;
            tx_data    = tx;
            slave_sh   = slv;
            slave_cnt  = 0;
        end
        @(negedge clk);
        chk({tag, "_start_resp"}, m_active, 1'b1);
        if (keep) begin
            start      = 1'b1;
            tx_data    = nxt;
            slave_next = nxt_slv;
        end else begin
            start      = 1'b0;
            tx_data    = ~tx;
        end
        n = 0; rises = 0; extra_done = 0; bits = 8'h00; prev = 1'b0;
        while (m_active === 1'b1 && n < 16 * div + 8) begin
            n++;
            if (m_sclk && !prev) begin
                bits = {bits[6:0], m_mosi};
                rises++;
            end
            prev = m_sclk;
            if (m_done) extra_done++;
            if (ign_cyc > 0 && n == ign_cyc) begin
                start   = 1'b1;
                tx_data = 8'hFF;
            end else if (ign_cyc > 0 && n == ign_cyc + 1) begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk({tag, "_active_len"}, n, 16 * div);
        chk({tag, "_rises"}, rises, 8);
        chk({tag, "_mosi_bits"}, bits, tx);
        chk({tag, "_done_early"}, extra_done, 0);
        chk({tag, "_done"}, m_done, 1'b1);
        chk({tag, "_rx"}, m_rx, expected_rx(tx, slv));
        chk({tag, "_sclk_end"}, m_sclk, 1'b0);
        if (!keep) begin
            @(negedge clk);
            chk({tag, "_done_once"}, m_done, 1'b0);
            chk({tag, "_idle_after"}, m_active, 1'b0);
            chk({tag, "_rx_hold"}, m_rx, expected_rx(tx, slv));
        end
    endtask

    initial begin
        logic [7:0] r_tx, r_slv;
        int n, r;
        logic prev;

        // Reset with no clock edges yet.
        #2;
        chk("rst_sclk4", if4.sclk, 1'b0);
        chk("rst_mosi4", if4.mosi, 1'b0);
        chk("rst_rx4", if4.rx_data, 8'h00);
        chk("rst_active4", if4.spi_active, 1'b0);
        chk("rst_done4", if4.done, 1'b0);
        chk("rst_sclk1", if1.sclk, 1'b0);
        chk("rst_active1", if1.spi_active, 1'b0);
        chk("rst_rx1", if1.rx_data, 8'h00);

        clk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle_quiet", {if4.sclk, if4.spi_active, if1.sclk, if1.spi_active}, 4'b0000);
        end

        sel = 1'b0;
        xfer("basic", 8'hA5, 8'h3C, 1'b1, 1'b0, 8'h00, 8'h00, 0);

        xfer("b2b_first", 8'h0B, 8'hD2, 1'b1, 1'b1, 8'h14, 8'h6E, 0);
        chk("b2b_gap", m_active, 1'b0);
        xfer("b2b_second", 8'h14, 8'h6E, 1'b0, 1'b0, 8'h00, 8'h00, 0);

        xfer("ignored_start", 8'h00, 8'h99, 1'b1, 1'b0, 8'h00, 8'h00, 32);

        for (int i = 0; i < 6; i++) begin
            r_tx  = 8'($urandom);
            r_slv = 8'($urandom);
            xfer("rand4", r_tx, r_slv, 1'b1, 1'b0, 8'h00, 8'h00, 0);
        end

        // Abort after the 3rd rising sclk edge.
        start = 1'b1; tx_data = 8'hC3; slave_sh = 8'h5A; slave_cnt = 0;
        @(negedge clk);
        start = 1'b0;
        n = 0; r = 0; prev = 1'b0;
        while (r < 3 && n < 200) begin
            if (m_sclk && !prev) r++;
            prev = m_sclk;
            @(negedge clk);
            n++;
        end
        chk("abort_reach", r, 3);
        #2 rst = 1'b1;
        #1;
        chk("abort_sclk", m_sclk, 1'b0);
        chk("abort_active", m_active, 1'b0);
        chk("abort_rx", m_rx, 8'h00);
        chk("abort_done", m_done, 1'b0);
        chk("abort_mosi", m_mosi, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_done", {m_done, m_active}, 2'b00);
        end
        rst = 1'b0;
        @(negedge clk);
        xfer("after_abort", 8'h55, 8'hE7, 1'b1, 1'b0, 8'h00, 8'h00, 0);

        sel = 1'b1;
        @(negedge clk);
        xfer("div1", 8'h81, 8'h4D, 1'b1, 1'b0, 8'h00, 8'h00, 0);
        for (int i = 0; i < 4; i++) begin
            r_tx  = 8'($urandom);
            r_slv = 8'($urandom);
            xfer("rand1", r_tx, r_slv, 1'b1, 1'b0, 8'h00, 8'h00, 0);
        end
        xfer("div1_b2b_first", 8'h3E, 8'hC1, 1'b1, 1'b1, 8'hB7, 8'h28, 0);
        chk("div1_b2b_gap", m_active, 1'b0);
        xfer("div1_b2b_second", 8'hB7, 8'h28, 1'b0, 1'b0, 8'h00, 8'h00, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
